decode_stage: RTL and testbench

//  DLX decode stage: consumes fetch outputs (OpCode, Function, Rs1/Rs2/Rd, Immediate, PCPlusFour).

---
 rtl/decode_stage.sv | 164 ++++++++++++++++
 tb/tb_decode_stage.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/decode_stage.sv
// DLX decode stage: async branch/jump decode to fetch, 32x32 GPR file, ID/EX pipeline register.
// Optional macro DECODE_WB_BYPASS_EN forwards a same-cycle writeback onto the GPR read ports.
module decode_stage #(
   parameter int unsigned LINK_REG = 31
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        stall,
   input  logic        flush,
   input  logic [5:0]  OpCode,
   input  logic [5:0]  Function,
   input  logic [31:0] PCPlusFour,
   input  logic [4:0]  Rs1,
   input  logic [4:0]  Rs2,
   input  logic [4:0]  Rd,
   input  logic [15:0] Immediate,
   input  logic        RegWrEn_WB,
   input  logic [4:0]  RegWrAddr_WB,
   input  logic [31:0] RegWrData_WB,
   output logic [1:0]  JumpType,
   output logic        BranchCond,
   output logic        CondSrc,
   output logic [31:0] RegA_Exe,
   output logic [31:0] RegB_Exe,
   output logic [31:0] Imm_Exe,
   output logic [31:0] PCPlusFour_Exe,
   output logic [5:0]  ALUOp_Exe,
   output logic [4:0]  RegWrAddr_Exe,
   output logic        RegWrEn_Exe,
   output logic        MemRd_Exe,
   output logic        MemWr_Exe,
   output logic        ALUSrc_Exe,
   output logic        Link_Exe,
   output logic        Valid_Exe
);

   localparam logic [4:0] LinkAddr = 5'(LINK_REG);

   typedef struct packed {
      logic [31:0] regA;
      logic [31:0] regB;
      logic [31:0] imm;
      logic [31:0] pc;
      logic [5:0]  aluOp;
      logic [4:0]  wrAddr;
      logic        wrEn;
      logic        memRd;
      logic        memWr;
      logic        aluSrc;
      logic        link;
      logic        valid;
   } idex_t;

   idex_t       idex_q, idex_d;
   logic [31:0] gpr_q [32];
   logic [31:0] rdA, rdB, immExt;
   logic [4:0]  destAddr;
   logic        isRType, isLoad, isStore, isAluImm, isLink, isJImm, isJumpBr;
   logic        isNop, bubble, writesReg;

   always_comb begin
      JumpType   = 2'b00;
      BranchCond = 1'b0;
      CondSrc    = 1'b0;
      case (OpCode)
         6'h02, 6'h03: JumpType = 2'b10;
         6'h12, 6'h13: JumpType = 2'b11;
         6'h04: begin JumpType = 2'b01; BranchCond = 1'b1; end
         6'h05: JumpType = 2'b01;
         6'h06: begin JumpType = 2'b01; CondSrc = 1'b1; end
         6'h07: begin JumpType = 2'b01; BranchCond = 1'b1; CondSrc = 1'b1; end
         default: ;
      endcase
   end

   always_comb begin
      isRType   = (OpCode == 6'h00);
      isLoad    = (OpCode >= 6'h20) && (OpCode <= 6'h25);
      isStore   = (OpCode >= 6'h28) && (OpCode <= 6'h2B);
      isAluImm  = (OpCode >= 6'h08) && (OpCode <= 6'h0F);
      isLink    = (OpCode == 6'h03) || (OpCode == 6'h13);
      isJImm    = (OpCode == 6'h02) || (OpCode == 6'h03);
      isJumpBr  = ((OpCode >= 6'h02) && (OpCode <= 6'h07)) || (OpCode == 6'h12) || (OpCode == 6'h13);
      isNop     = isRType && (Function == 6'h00) && (Rs1 == 5'd0) && (Rs2 == 5'd0)
                  && (Rd == 5'd0) && (Immediate == 16'h0000);
      bubble    = isNop || !(isRType || isLoad || isStore || isAluImm || isJumpBr);
      writesReg = isRType || isLoad || isAluImm || isLink;
      destAddr  = isLink ? LinkAddr : (isRType ? Rd : Rs2);
   end

   // J/JAL carry a 26-bit offset spread over the Rs1/Rs2/Immediate fields.
   always_comb begin
      if (isJImm)
         immExt = {{6{Rs1[4]}}, Rs1, Rs2, Immediate};
      else if (OpCode == 6'h0F)
         immExt = {Immediate, 16'h0000};
      else if ((OpCode >= 6'h0C) && (OpCode <= 6'h0E))
         immExt = {16'h0000, Immediate};
      else
         immExt = {{16{Immediate[15]}}, Immediate};
   end

   always_comb begin
      rdA = (Rs1 == 5'd0) ? 32'h0 : gpr_q[Rs1];
      rdB = (Rs2 == 5'd0) ? 32'h0 : gpr_q[Rs2];
`ifdef DECODE_WB_BYPASS_EN
      if (RegWrEn_WB && (RegWrAddr_WB != 5'd0) && (RegWrAddr_WB == Rs1))
         rdA = RegWrData_WB;
      if (RegWrEn_WB && (RegWrAddr_WB != 5'd0) && (RegWrAddr_WB == Rs2))
         rdB = RegWrData_WB;
`endif
   end

   always_comb begin
      idex_d = idex_q;
      if (flush || (!stall && bubble)) begin
         idex_d = '0;
      end else if (!stall) begin
         idex_d.regA   = rdA;
         idex_d.regB   = rdB;
         idex_d.imm    = immExt;
         idex_d.pc     = PCPlusFour;
         idex_d.aluOp  = isRType ? Function : OpCode;
         idex_d.wrAddr = destAddr;
         idex_d.wrEn   = writesReg && (destAddr != 5'd0);
         idex_d.memRd  = isLoad;
         idex_d.memWr  = isStore;
         idex_d.aluSrc = isAluImm;
         idex_d.link   = isLink;
         idex_d.valid  = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         idex_q <= '0;
      else
         idex_q <= idex_d;
   end

   // Writeback is never gated by stall/flush: retiring instructions must still land.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < 32; i++)
            gpr_q[i] <= 32'h0;
      end else if (RegWrEn_WB && (RegWrAddr_WB != 5'd0)) begin
         gpr_q[RegWrAddr_WB] <= RegWrData_WB;
      end
   end

   assign RegA_Exe       = idex_q.regA;
   assign RegB_Exe       = idex_q.regB;
   assign Imm_Exe        = idex_q.imm;
   assign PCPlusFour_Exe = idex_q.pc;
   assign ALUOp_Exe      = idex_q.aluOp;
   assign RegWrAddr_Exe  = idex_q.wrAddr;
   assign RegWrEn_Exe    = idex_q.wrEn;
   assign MemRd_Exe      = idex_q.memRd;
   assign MemWr_Exe      = idex_q.memWr;
   assign ALUSrc_Exe     = idex_q.aluSrc;
   assign Link_Exe       = idex_q.link;
   assign Valid_Exe      = idex_q.valid;

endmodule

// File: tb/tb_decode_stage.sv
// Scoreboard bench for decode_stage: directed vectors push hand-computed ID/EX results,
// a monitor pops and compares one entry per clock edge.
module tb_decode_stage;

   logic        clk = 1'b0;
   logic        reset, stall, flush;
   logic [5:0]  OpCode, Function;
   logic [31:0] PCPlusFour;
   logic [4:0]  Rs1, Rs2, Rd;
   logic [15:0] Immediate;
   logic        RegWrEn_WB;
   logic [4:0]  RegWrAddr_WB;
   logic [31:0] RegWrData_WB;
   logic [1:0]  JumpType;
   logic        BranchCond, CondSrc;
   logic [31:0] RegA_Exe, RegB_Exe, Imm_Exe, PCPlusFour_Exe;
   logic [5:0]  ALUOp_Exe;
   logic [4:0]  RegWrAddr_Exe;
   logic        RegWrEn_Exe, MemRd_Exe, MemWr_Exe, ALUSrc_Exe, Link_Exe, Valid_Exe;

   typedef struct packed {
      logic [15:0] id;
      logic [31:0] regA;
      logic [31:0] regB;
      logic [31:0] imm;
      logic [31:0] pc;
      logic [5:0]  aluOp;
      logic [4:0]  wrAddr;
      logic [5:0]  ctrl;
   } exp_t;

   exp_t        sb[$];
   exp_t        lastExp;
   exp_t        bubbleE;
   int          checks = 0;
   int          failures = 0;
   int          stepId = 0;
   logic [31:0] r7Exp;

   decode_stage dut (
      .clk(clk), .reset(reset), .stall(stall), .flush(flush),
      .OpCode(OpCode), .Function(Function), .PCPlusFour(PCPlusFour),
      .Rs1(Rs1), .Rs2(Rs2), .Rd(Rd), .Immediate(Immediate),
      .RegWrEn_WB(RegWrEn_WB), .RegWrAddr_WB(RegWrAddr_WB), .RegWrData_WB(RegWrData_WB),
      .JumpType(JumpType), .BranchCond(BranchCond), .CondSrc(CondSrc),
      .RegA_Exe(RegA_Exe), .RegB_Exe(RegB_Exe), .Imm_Exe(Imm_Exe),
      .PCPlusFour_Exe(PCPlusFour_Exe), .ALUOp_Exe(ALUOp_Exe), .RegWrAddr_Exe(RegWrAddr_Exe),
      .RegWrEn_Exe(RegWrEn_Exe), .MemRd_Exe(MemRd_Exe), .MemWr_Exe(MemWr_Exe),
      .ALUSrc_Exe(ALUSrc_Exe), .Link_Exe(Link_Exe), .Valid_Exe(Valid_Exe)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input int id, input logic [31:0] act,
                              input logic [31:0] want);
      checks++;
      if (act !== want) begin
         failures++;
         $display("[TB] FAIL %s step=%0d got=%h want=%h", name, id, act, want);
      end
   endtask

   function automatic exp_t mk(input logic [31:0] a, b, imm, pc, input logic [5:0] op,
                               input logic [4:0] wa, input logic wrEn, memRd, memWr,
                               aluSrc, link);
      exp_t e;
      e.id     = '0;
      e.regA   = a;
      e.regB   = b;
      e.imm    = imm;
      e.pc     = pc;
      e.aluOp  = op;
      e.wrAddr = wa;
      e.ctrl   = {wrEn, memRd, memWr, aluSrc, link, 1'b1};
      return e;
   endfunction

   // Drives one instruction between edges, checks the async decode, queues the ID/EX result.
   task automatic applyStimulus(input logic [5:0] op, fn, input logic [4:0] s1, s2, d,
                                input logic [15:0] imm, input logic [31:0] pc,
                                input logic stl, fl, wbEn, input logic [4:0] wbA,
                                input logic [31:0] wbD, input logic [3:0] asyncExp,
                                input exp_t e);
      @(negedge clk);
      OpCode = op; Function = fn; Rs1 = s1; Rs2 = s2; Rd = d; Immediate = imm;
      PCPlusFour = pc; stall = stl; flush = fl;
      RegWrEn_WB = wbEn; RegWrAddr_WB = wbA; RegWrData_WB = wbD;
      #1;
      e.id = 16'(stepId);
      checkOutput("async", stepId, {28'h0, JumpType, BranchCond, CondSrc}, {28'h0, asyncExp});
      sb.push_back(e);
      lastExp = e;
      stepId++;
   endtask

   task automatic checkAllZero(input string name);
      checkOutput({name, ".regA"}, stepId, RegA_Exe, 32'h0);
      checkOutput({name, ".regB"}, stepId, RegB_Exe, 32'h0);
      checkOutput({name, ".imm"}, stepId, Imm_Exe, 32'h0);
      checkOutput({name, ".pc"}, stepId, PCPlusFour_Exe, 32'h0);
      checkOutput({name, ".aluOp"}, stepId, {26'h0, ALUOp_Exe}, 32'h0);
      checkOutput({name, ".wrAddr"}, stepId, {27'h0, RegWrAddr_Exe}, 32'h0);
      checkOutput({name, ".ctrl"}, stepId,
                  {26'h0, RegWrEn_Exe, MemRd_Exe, MemWr_Exe, ALUSrc_Exe, Link_Exe, Valid_Exe}, 32'h0);
   endtask

   // Monitor: every entry queued before an edge is the ID/EX content expected after it.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (sb.size() > 0) begin
            e = sb.pop_front();
            checkOutput("regA", int'(e.id), RegA_Exe, e.regA);
            checkOutput("regB", int'(e.id), RegB_Exe, e.regB);
            checkOutput("imm", int'(e.id), Imm_Exe, e.imm);
            checkOutput("pc", int'(e.id), PCPlusFour_Exe, e.pc);
            checkOutput("aluOp", int'(e.id), {26'h0, ALUOp_Exe}, {26'h0, e.aluOp});
            checkOutput("wrAddr", int'(e.id), {27'h0, RegWrAddr_Exe}, {27'h0, e.wrAddr});
            checkOutput("ctrl", int'(e.id),
                        {26'h0, RegWrEn_Exe, MemRd_Exe, MemWr_Exe, ALUSrc_Exe, Link_Exe, Valid_Exe},
                        {26'h0, e.ctrl});
         end
      end
   end

   initial begin
      #100000;
      $display("[TB] FAIL watchdog step=%0d got=timeout want=finish", stepId);
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      bubbleE = '0;
      reset = 1'b1; stall = 1'b0; flush = 1'b0;
      OpCode = '0; Function = '0; PCPlusFour = '0; Rs1 = '0; Rs2 = '0; Rd = '0;
      Immediate = '0; RegWrEn_WB = 1'b0; RegWrAddr_WB = '0; RegWrData_WB = '0;
      repeat (3) @(posedge clk);
      #1 checkAllZero("resetInit");
      @(negedge clk);
      reset = 1'b0;

      // Reset in the middle of a valid stream clears ID/EX and the GPRs
      applyStimulus(6'h00, 6'h00, 0, 0, 0, 16'h0, 32'h0, 0, 0, 1, 5, 32'h55, 4'h0, bubbleE);
      applyStimulus(6'h00, 6'h20, 5, 0, 3, 16'h0, 32'h100, 0, 0, 0, 0, 0, 4'h0,
                    mk(32'h55, 0, 0, 32'h100, 6'h20, 3, 1, 0, 0, 0, 0));
      @(negedge clk);
      OpCode = 6'h00; Function = 6'h20; Rs1 = 5; Rs2 = 0; Rd = 3; PCPlusFour = 32'h104;
      #2 reset = 1'b1;
      #1 checkAllZero("resetMid");
      @(negedge clk);
      reset = 1'b0;
      applyStimulus(6'h00, 6'h20, 5, 0, 3, 16'h0, 32'h108, 0, 0, 0, 0, 0, 4'h0,
                    mk(0, 0, 0, 32'h108, 6'h20, 3, 1, 0, 0, 0, 0));

      // Writeback then read, same-cycle read, R0 write ignored
      applyStimulus(6'h00, 6'h00, 0, 0, 0, 16'h0, 32'h0, 0, 0, 1, 5, 32'hDEAD_BEEF, 4'h0, bubbleE);
      applyStimulus(6'h00, 6'h20, 5, 0, 9, 16'h0, 32'h200, 0, 0, 0, 0, 0, 4'h0,
                    mk(32'hDEAD_BEEF, 0, 0, 32'h200, 6'h20, 9, 1, 0, 0, 0, 0));
      applyStimulus(6'h00, 6'h00, 0, 0, 0, 16'h0, 32'h0, 0, 0, 1, 7, 32'h1111, 4'h0, bubbleE);
`ifdef DECODE_WB_BYPASS_EN
      r7Exp = 32'h1234;
`else
      r7Exp = 32'h1111;
`endif
      applyStimulus(6'h00, 6'h22, 7, 7, 4, 16'h0, 32'h204, 0, 0, 1, 7, 32'h1234, 4'h0,
                    mk(r7Exp, r7Exp, 0, 32'h204, 6'h22, 4, 1, 0, 0, 0, 0));
      applyStimulus(6'h00, 6'h22, 7, 7, 4, 16'h0, 32'h208, 0, 0, 0, 0, 0, 4'h0,
                    mk(32'h1234, 32'h1234, 0, 32'h208, 6'h22, 4, 1, 0, 0, 0, 0));
      applyStimulus(6'h00, 6'h00, 0, 0, 0, 16'h0, 32'h0, 0, 0, 1, 0, 32'hFFFF_FFFF, 4'h0, bubbleE);
      applyStimulus(6'h00, 6'h20, 0, 0, 1, 16'h0, 32'h20C, 0, 0, 0, 0, 0, 4'h0,
                    mk(0, 0, 0, 32'h20C, 6'h20, 1, 1, 0, 0, 0, 0));

      // Branch and jump decode
      applyStimulus(6'h04, 6'h00, 2, 0, 0, 16'h0010, 32'h300, 0, 0, 0, 0, 0, 4'b0110,
                    mk(0, 0, 32'h10, 32'h300, 6'h04, 0, 0, 0, 0, 0, 0));
      applyStimulus(6'h06, 6'h00, 0, 0, 0, 16'hFFFC, 32'h304, 0, 0, 0, 0, 0, 4'b0101,
                    mk(0, 0, 32'hFFFF_FFFC, 32'h304, 6'h06, 0, 0, 0, 0, 0, 0));
      applyStimulus(6'h13, 6'h00, 5, 0, 0, 16'h0, 32'h400, 0, 0, 0, 0, 0, 4'b1100,
                    mk(32'hDEAD_BEEF, 0, 0, 32'h400, 6'h13, 31, 1, 0, 0, 0, 1));
      applyStimulus(6'h02, 6'h00, 16, 0, 0, 16'h0004, 32'h404, 0, 0, 0, 0, 0, 4'b1000,
                    mk(0, 0, 32'hFE00_0004, 32'h404, 6'h02, 0, 0, 0, 0, 0, 0));
      applyStimulus(6'h03, 6'h00, 0, 1, 0, 16'h0008, 32'h408, 0, 0, 0, 0, 0, 4'b1000,
                    mk(0, 0, 32'h0001_0008, 32'h408, 6'h03, 31, 1, 0, 0, 0, 1));

      // Immediate extension, R0 destination, memory ops, unknown opcode
      applyStimulus(6'h08, 6'h00, 5, 6, 0, 16'h8000, 32'h500, 0, 0, 0, 0, 0, 4'h0,
                    mk(32'hDEAD_BEEF, 0, 32'hFFFF_8000, 32'h500, 6'h08, 6, 1, 0, 0, 1, 0));
      applyStimulus(6'h0D, 6'h00, 0, 6, 0, 16'h8000, 32'h504, 0, 0, 0, 0, 0, 4'h0,
                    mk(0, 0, 32'h0000_8000, 32'h504, 6'h0D, 6, 1, 0, 0, 1, 0));
      applyStimulus(6'h0F, 6'h00, 0, 6, 0, 16'h8000, 32'h508, 0, 0, 0, 0, 0, 4'h0,
                    mk(0, 0, 32'h8000_0000, 32'h508, 6'h0F, 6, 1, 0, 0, 1, 0));
      applyStimulus(6'h08, 6'h00, 0, 0, 0, 16'h8000, 32'h50C, 0, 0, 0, 0, 0, 4'h0,
                    mk(0, 0, 32'hFFFF_8000, 32'h50C, 6'h08, 0, 0, 0, 0, 1, 0));
      applyStimulus(6'h23, 6'h00, 5, 8, 0, 16'h0004, 32'h510, 0, 0, 0, 0, 0, 4'h0,
                    mk(32'hDEAD_BEEF, 0, 32'h4, 32'h510, 6'h23, 8, 1, 1, 0, 0, 0));
      applyStimulus(6'h2B, 6'h00, 0, 5, 0, 16'hFFFC, 32'h514, 0, 0, 0, 0, 0, 4'h0,
                    mk(0, 32'hDEAD_BEEF, 32'hFFFF_FFFC, 32'h514, 6'h2B, 5, 0, 0, 1, 0, 0));
      applyStimulus(6'h3F, 6'h00, 5, 5, 0, 16'h1234, 32'h518, 0, 0, 0, 0, 0, 4'h0, bubbleE);

      // Stall holds (writeback still lands), stall+flush loads a bubble
      applyStimulus(6'h00, 6'h20, 5, 7, 10, 16'h0, 32'h600, 0, 0, 0, 0, 0, 4'h0,
                    mk(32'hDEAD_BEEF, 32'h1234, 0, 32'h600, 6'h20, 10, 1, 0, 0, 0, 0));
      applyStimulus(6'h2B, 6'h00, 1, 2, 0, 16'h0040, 32'h604, 1, 0, 1, 5, 32'h77, 4'h0, lastExp);
      applyStimulus(6'h04, 6'h00, 3, 4, 0, 16'h0080, 32'h608, 1, 0, 0, 0, 0, 4'b0110, lastExp);
      applyStimulus(6'h00, 6'h20, 5, 0, 11, 16'h0, 32'h608, 0, 0, 0, 0, 0, 4'h0,
                    mk(32'h77, 0, 0, 32'h608, 6'h20, 11, 1, 0, 0, 0, 0));
      applyStimulus(6'h2B, 6'h00, 0, 5, 0, 16'h0008, 32'h60C, 0, 0, 0, 0, 0, 4'h0,
                    mk(0, 32'h77, 32'h8, 32'h60C, 6'h2B, 5, 0, 0, 1, 0, 0));
      applyStimulus(6'h2B, 6'h00, 0, 5, 0, 16'h0010, 32'h610, 1, 1, 0, 0, 0, 4'h0, bubbleE);

      @(negedge clk);
      stall = 1'b0; flush = 1'b0;
      repeat (3) @(posedge clk);
      #2 checkOutput("drain", stepId, 32'(sb.size()), 32'h0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
